reorder_buffer: RTL

- Circular in-order reorder buffer for the RV32I out-of-order core.
- Accepts instructions from the instruction unit and collects results from the common data bus (CDB).
- Retires one instruction per cycle, in order, by driving the register-file commit port.
- Answers the register file's rs1/rs2 dependency queries, signals store commits to the load/store buffer, and raises a pipeline flush on a mispredicted branch.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/reorder_buffer_if.sv | 55 +++++
 rtl/rob_query_port.sv | 21 ++
 rtl/reorder_buffer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: core-level index width, entry type
// encodings and the per-entry storage record.
package rob_pkg;

    localparam int ROB_WIDTH = 4;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2
    } robType_t;

    typedef struct packed {
        logic        busy;
        logic        ready;
        robType_t    kind;
        logic [4:0]  dest;
        logic [31:0] value;
        logic        predTaken;
        logic        taken;
        logic [31:0] target;
    } robEntry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of every reorder-buffer connection other than clock and reset.
// The core side uses the master modport, the buffer itself uses slave.
interface reorder_buffer_if #(parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH);

    logic                 issueValid;
    logic [1:0]           issueType;
    logic [4:0]           issueDest;
    logic                 issuePredTaken;
    logic                 robFull;
    logic [ROB_WIDTH-1:0] robTailId;

    logic                 cdbValid;
    logic [ROB_WIDTH-1:0] cdbRobId;
    logic [31:0]          cdbValue;
    logic                 cdbTaken;
    logic [31:0]          cdbTarget;

    logic                 regUpdateValid;
    logic [4:0]           regUpdateDest;
    logic [31:0]          regValue;
    logic [ROB_WIDTH-1:0] regUpdateRobId;

    logic [ROB_WIDTH-1:0] robRs1Dep;
    logic                 robRs1Ready;
    logic [31:0]          robRs1Value;
    logic [ROB_WIDTH-1:0] robRs2Dep;
    logic                 robRs2Ready;
    logic [31:0]          robRs2Value;

    logic                 storeCommit;
    logic [ROB_WIDTH-1:0] storeRobId;
    logic                 clearOut;
    logic [31:0]          newPc;

    modport master (
        output issueValid, issueType, issueDest, issuePredTaken,
        output cdbValid, cdbRobId, cdbValue, cdbTaken, cdbTarget,
        output robRs1Dep, robRs2Dep,
        input  robFull, robTailId,
        input  regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  robRs1Ready, robRs1Value, robRs2Ready, robRs2Value,
        input  storeCommit, storeRobId, clearOut, newPc
    );

    modport slave (
        input  issueValid, issueType, issueDest, issuePredTaken,
        input  cdbValid, cdbRobId, cdbValue, cdbTaken, cdbTarget,
        input  robRs1Dep, robRs2Dep,
        output robFull, robTailId,
        output regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output robRs1Ready, robRs1Value, robRs2Ready, robRs2Value,
        output storeCommit, storeRobId, clearOut, newPc
    );

endinterface

// File: rtl/rob_query_port.sv
// One operand dependency lookup: an entry is usable if it already holds its
// result or the CDB is broadcasting that result in the same cycle.
module rob_query_port #(parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH) (
    input  logic [ROB_WIDTH-1:0] dep,
    input  logic                 entryBusy,
    input  logic                 entryReady,
    input  logic [31:0]          entryValue,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbRobId,
    input  logic [31:0]          cdbValue,
    output logic                 depReady,
    output logic [31:0]          depValue
);

    logic cdbHit;

    assign cdbHit   = cdbValid && (cdbRobId == dep);
    assign depReady = entryBusy && (entryReady || cdbHit);
    assign depValue = cdbHit ? cdbValue : entryValue;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail, fills from the CDB,
// retires one entry per cycle at head and flushes on a branch mispredict.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH
) (
    input  logic             clockIn,
    input  logic             resetIn,
    reorder_buffer_if.slave  bus
);

    localparam int DEPTH = 2 ** ROB_WIDTH;

    robEntry_t            entries [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    robEntry_t headEntry;
    logic      robFull;
    logic      doIssue;
    logic      doWriteBack;
    logic      doCommit;
    logic      mispredict;

    assign headEntry   = entries[head];
    assign robFull     = (count == (ROB_WIDTH+1)'(DEPTH));
    assign doIssue     = bus.issueValid && !robFull;
    assign doWriteBack = bus.cdbValid && entries[bus.cdbRobId].busy;
    assign doCommit    = (count != '0) && headEntry.busy && headEntry.ready;
    assign mispredict  = doCommit && (headEntry.kind == ROB_BRANCH)
                         && (headEntry.taken != headEntry.predTaken);

    assign bus.robFull   = robFull;
    assign bus.robTailId = tail;

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) rs1Query (
        .dep        (bus.robRs1Dep),
        .entryBusy  (entries[bus.robRs1Dep].busy),
        .entryReady (entries[bus.robRs1Dep].ready),
        .entryValue (entries[bus.robRs1Dep].value),
        .cdbValid   (bus.cdbValid),
        .cdbRobId   (bus.cdbRobId),
        .cdbValue   (bus.cdbValue),
        .depReady   (bus.robRs1Ready),
        .depValue   (bus.robRs1Value)
    );

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) rs2Query (
        .dep        (bus.robRs2Dep),
        .entryBusy  (entries[bus.robRs2Dep].busy),
        .entryReady (entries[bus.robRs2Dep].ready),
        .entryValue (entries[bus.robRs2Dep].value),
        .cdbValid   (bus.cdbValid),
        .cdbRobId   (bus.cdbRobId),
        .cdbValue   (bus.cdbValue),
        .depReady   (bus.robRs2Ready),
        .depValue   (bus.robRs2Value)
    );

    // Commit pulses default low every edge; a mispredict wipes the whole
    // window and swallows any issue or write-back arriving on that edge.
    always_ff @(posedge clockIn) begin
        bus.regUpdateValid <= 1'b0;
        bus.storeCommit    <= 1'b0;
        bus.clearOut       <= 1'b0;
        if (resetIn) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            bus.newPc          <= '0;
            bus.regValue       <= '0;
            bus.regUpdateDest  <= '0;
            bus.regUpdateRobId <= '0;
            bus.storeRobId     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else if (mispredict) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            bus.clearOut <= 1'b1;
            bus.newPc    <= headEntry.target;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (doIssue) begin
                entries[tail].busy      <= 1'b1;
                entries[tail].ready     <= 1'b0;
                entries[tail].kind      <= robType_t'(bus.issueType);
                entries[tail].dest      <= bus.issueDest;
                entries[tail].predTaken <= bus.issuePredTaken;
                tail                    <= tail + 1'b1;
            end
            if (doWriteBack) begin
                entries[bus.cdbRobId].value  <= bus.cdbValue;
                entries[bus.cdbRobId].taken  <= bus.cdbTaken;
                entries[bus.cdbRobId].target <= bus.cdbTarget;
                entries[bus.cdbRobId].ready  <= 1'b1;
            end
            // Placed after the write-back so retiring the head always wins.
            if (doCommit) begin
                entries[head].busy  <= 1'b0;
                entries[head].ready <= 1'b0;
                head                <= head + 1'b1;
                if (headEntry.kind == ROB_REG) begin
                    bus.regUpdateValid <= 1'b1;
                    bus.regUpdateDest  <= headEntry.dest;
                    bus.regValue       <= headEntry.value;
                    bus.regUpdateRobId <= head;
                end else if (headEntry.kind == ROB_STORE) begin
                    bus.storeCommit <= 1'b1;
                    bus.storeRobId  <= head;
                end
            end
            count <= count + (ROB_WIDTH+1)'(doIssue) - (ROB_WIDTH+1)'(doCommit);
        end
    end

endmodule
